// File: rtl/mvm_result_sink.sv
// AXI-Stream result sink: buffers {TLAST, TDATA} beats in a show-ahead FIFO and keeps packet statistics.
// Optional destination check is built when MVM_RESULT_SINK_DEST_CHECK_EN is defined.
module mvm_result_sink #(
  parameter int DATAW = 512,
  parameter int IDW   = 5,
  parameter int DESTW = 12,
  parameter int USERW = 75,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             AXIS_S_TVALID,
  output logic             AXIS_S_TREADY,
  input  logic [DATAW-1:0] AXIS_S_TDATA,
  input  logic             AXIS_S_TLAST,
  input  logic [IDW-1:0]   AXIS_S_TID,
  input  logic [USERW-1:0] AXIS_S_TUSER,
  input  logic [DESTW-1:0] AXIS_S_TDEST,
  input  logic [DESTW-1:0] EXP_DEST,
  input  logic             RD_EN,
  output logic             RD_VALID,
  output logic [DATAW-1:0] RD_DATA,
  output logic             RD_LAST,
  output logic             PKT_DONE,
  output logic [15:0]      PKT_COUNT,
  output logic [7:0]       LAST_PKT_BEATS,
  output logic             DEST_ERR,
  output logic             DBG_STATE
);

  localparam int ADDRW = $clog2(DEPTH);
  localparam logic [ADDRW:0] FULL_CNT = (ADDRW + 1)'(DEPTH);
  localparam logic [ADDRW:0] ONE_CNT  = (ADDRW + 1)'(1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_e;

  // Handshake: a beat transfers on a rising CLK edge where TVALID and TREADY
  // are both 1; TREADY comes only from a flop, so it never depends on TVALID
  // or RD_EN in the same cycle. RD_EN pops the head only while RD_VALID is 1.

  logic [DATAW:0]   mem [DEPTH];
  logic [ADDRW-1:0] wr_ptr;
  logic [ADDRW-1:0] rd_ptr;
  logic [ADDRW:0]   occ;
  logic [ADDRW:0]   occ_nxt;
  logic             tready_q;
  logic             empty;
  logic             accept;
  logic             pop;
  logic [DATAW:0]   head;

  pkt_state_e       state;
  logic [7:0]       beat_cnt;
  logic [7:0]       beat_inc;

  assign empty  = (occ == '0);
  assign accept = AXIS_S_TVALID & tready_q;
  assign pop    = RD_EN & ~empty;

  always_comb begin
    occ_nxt = occ;
    case ({accept, pop})
      2'b10:   occ_nxt = occ + ONE_CNT;
      2'b01:   occ_nxt = occ - ONE_CNT;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      tready_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      occ      <= occ_nxt;
      tready_q <= (occ_nxt != FULL_CNT);
    end
  end

  // Storage is not reset; the empty flag masks stale entries on the read side.
  always_ff @(posedge CLK) begin
    if (accept) mem[wr_ptr] <= {AXIS_S_TLAST, AXIS_S_TDATA};
  end

  assign head          = mem[rd_ptr];
  assign AXIS_S_TREADY = tready_q;
  assign RD_VALID      = ~empty;
  assign RD_DATA       = empty ? '0 : head[DATAW-1:0];
  assign RD_LAST       = ~empty & head[DATAW];

  assign beat_inc = (beat_cnt == 8'hFF) ? 8'hFF : beat_cnt + 8'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= ST_IDLE;
      beat_cnt       <= '0;
      PKT_DONE       <= 1'b0;
      PKT_COUNT      <= '0;
      LAST_PKT_BEATS <= '0;
    end else begin
      PKT_DONE <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (AXIS_S_TLAST) begin
              LAST_PKT_BEATS <= beat_inc;
              beat_cnt       <= '0;
              PKT_DONE       <= 1'b1;
              PKT_COUNT      <= PKT_COUNT + 16'd1;
            end else begin
              beat_cnt <= beat_inc;
              state    <= ST_IN_PKT;
            end
          end
          ST_IN_PKT: begin
            if (AXIS_S_TLAST) begin
              LAST_PKT_BEATS <= beat_inc;
              beat_cnt       <= '0;
              PKT_DONE       <= 1'b1;
              PKT_COUNT      <= PKT_COUNT + 16'd1;
              state          <= ST_IDLE;
            end else begin
              beat_cnt <= beat_inc;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign DBG_STATE = state;

`ifdef MVM_RESULT_SINK_DEST_CHECK_EN
  logic dest_err_q;
  logic unused_sink;

  // Only the first beat of a packet carries a meaningful destination.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dest_err_q <= 1'b0;
    end else if (accept && (state == ST_IDLE) && (AXIS_S_TDEST != EXP_DEST)) begin
      dest_err_q <= 1'b1;
    end
  end

  assign DEST_ERR    = dest_err_q;
  assign unused_sink = ^{AXIS_S_TID, AXIS_S_TUSER};
`else
  logic unused_sink;

  assign DEST_ERR    = 1'b0;
  assign unused_sink = ^{AXIS_S_TID, AXIS_S_TUSER, AXIS_S_TDEST, EXP_DEST};
`endif

endmodule
